bf16_adder: RTL and testbench
=============================

// Module: bf16_adder
// PURPOSE
//  Single-stage pipelined bfloat16 adder: c = a + b, IEEE-754 semantics, round-to-nearest-even.
//  Operands arrive as separate sign/exponent/mantissa fields; the result is registered and has 1-cycle latency.
//  Leaf arithmetic block for the BF16 datapath (accumulators, FMA post-add).
//  Subnormals are flushed to zero on both input and output.
// PARAMETERS
//  none (format fixed: 1 sign, 8 exponent bits with bias 127, 7 fraction bits)
// PORTS
//  clk      in   1  clock; all state updates on rising edge
//  nreset   in   1  synchronous active-low reset, sampled on rising edge of clk
//  valid_i  in   1  operand fields are valid this cycle
//  sa_i     in   1  operand A sign
//  ea_i     in   8  operand A biased exponent
//  ma_i     in   7  operand A fraction (hidden bit implied)
//  sb_i     in   1  operand B sign
//  eb_i     in   8  operand B biased exponent
//  mb_i     in   7  operand B fraction
//  valid_o  out  1  result valid; equals valid_i delayed by one cycle
//  s_o      out  1  result sign
//  e_o      out  8  result biased exponent
//  m_o      out  7  result fraction
// BEHAVIOUR
//  - Reset: when nreset=0 at a clk edge: valid_o=0 and {s_o,e_o,m_o} = +0 (0/0x00/0x00).
//  - Latency 1: inputs sampled at edge N appear on outputs after edge N. Outputs update every cycle.
//  - valid_i only qualifies valid_o; there is no backpressure, and a new operation may start every cycle.
//  - Classification per operand:
//    - e=0x00: zero (DAZ; fraction ignored)
//    - e=0xFF with m=0: Inf
//    - e=0xFF with m!=0: NaN
//    - otherwise: normal, with significand 1.m
//  - Specials, in priority order:
//    - any NaN -> canonical qNaN 0/0xFF/0x40
//    - +Inf + -Inf -> canonical qNaN
//    - Inf + x -> that Inf
//    - zero + y (y nonzero) -> y unchanged, including y's sign
//    - zero + zero -> +0, unless both are -0, in which case -0
//  - Normal path:
//    - Swap so |A| >= |B|, comparing {e,m}.
//    - Align B right by ea-eb, keeping guard, round and sticky bits. Shift distance saturates at 10 (B collapses to sticky).
//    - Signs equal: add significands. A carry-out shifts right 1 and increments the exponent.
//    - Signs differ: subtract. Normalise left using leading-zero count; exponent -= count.
//    - Exact cancellation (difference = 0) -> +0.
//    - Round to nearest, ties to even on the 7-bit fraction. A rounding carry renormalises and increments the exponent.
//    - Result sign = sign of the larger-magnitude operand.
//  - Range:
//    - Final exponent >= 0xFF -> +/-Inf (0xFF/0x00) with the result sign.
//    - Final exponent <= 0 (underflow) -> signed zero with the result sign (FTZ).
//  - Internal width: 1 hidden + 7 fraction + carry + guard/round/sticky; exponent kept in 10-bit signed.
//  - Fully combinational datapath into one output register stage; no FSM.
//  - Reset asserted mid-stream discards the in-flight result.
// TESTING
//  - Zeros: +0 + +0 -> +0; +0 + -0 -> +0; -0 + -0 -> -0; -0 + 1.0 (0/0x7F/0x00) -> 0/0x7F/0x00.
//  - Basic: 1.0 + 1.0 (0x3F80 + 0x3F80) -> 0x4000; 1.0 + -1.0 -> +0 (0x0000).
//  - RNE ties: 0x3F80 + 0x3B80 -> 0x3F80; 0x3F81 + 0x3B80 -> 0x3F82.
//  - Overflow and specials:
//    - 0x7F7F + 0x7F7F -> 0x7F80 (+Inf)
//    - 0x7F80 + 0xFF80 -> 0x7FC0
//    - NaN 0x7F81 + 1.0 -> 0x7FC0
//    - -Inf 0xFF80 + 1.0 -> 0xFF80
//  - Subnormal flush: 0x0001 + 0x0000 -> 0x0000; 0x0080 + 0x8080 (cancellation) -> 0x0000.
//  - Timing and reset:
//    - valid_i pulse appears on valid_o exactly 1 cycle later.
//    - Back-to-back inputs produce back-to-back results.
//    - nreset=0 mid-stream forces valid_o=0 and outputs to +0 on the next edge.

Source files
------------

// File: rtl/bf16_adder_if.sv
// Operand/result bundle for the bfloat16 adder.
//   valid_i, sa_i/ea_i/ma_i, sb_i/eb_i/mb_i : operand fields from the producer
//   valid_o, s_o/e_o/m_o                    : registered result back to the producer
// master = the side that supplies operands; slave = the adder itself.
interface bf16_adder_if;
   logic       valid_i;
   logic       sa_i;
   logic [7:0] ea_i;
   logic [6:0] ma_i;
   logic       sb_i;
   logic [7:0] eb_i;
   logic [6:0] mb_i;
   logic       valid_o;
   logic       s_o;
   logic [7:0] e_o;
   logic [6:0] m_o;

   modport master (
      output valid_i, sa_i, ea_i, ma_i, sb_i, eb_i, mb_i,
      input  valid_o, s_o, e_o, m_o
   );

   modport slave (
      input  valid_i, sa_i, ea_i, ma_i, sb_i, eb_i, mb_i,
      output valid_o, s_o, e_o, m_o
   );
endinterface

// File: rtl/bf16_adder.sv
// bfloat16 adder, c = a + b, round-to-nearest-even, one register stage.
// Subnormal operands are treated as zero and underflowing results flush to
// a signed zero.
//   clk    : clock, all state on the rising edge
//   nreset : synchronous active-low reset; clears valid_o and the result to +0
//   bus    : bf16_adder_if.slave carrying operand fields in and result out
module bf16_adder (
   input  logic         clk,
   input  logic         nreset,
   bf16_adder_if.slave  bus
);

   // operand classification
   logic a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;

   // normal path
   logic              swap;
   logic              s_l, s_s;
   logic [7:0]        e_l, e_s, e_diff;
   logic [7:0]        m_l, m_s;
   logic [3:0]        sh;
   logic [10:0]       ext_l, ext_s, aligned;
   logic              lost;
   logic [11:0]       sum;
   logic [3:0]        lzc, lzc_eff;
   logic              found;
   logic [10:0]       norm;
   logic              round_up;
   logic [8:0]        mant_r;
   logic [6:0]        frac_r;
   logic signed [9:0] exp_r;

   logic [15:0] res_next;
   logic [15:0] res_reg;
   logic        valid_reg;

   always_comb begin
      a_zero = (bus.ea_i == 8'h00);
      b_zero = (bus.eb_i == 8'h00);
      a_inf  = (bus.ea_i == 8'hFF) && (bus.ma_i == 7'h00);
      b_inf  = (bus.eb_i == 8'hFF) && (bus.mb_i == 7'h00);
      a_nan  = (bus.ea_i == 8'hFF) && (bus.ma_i != 7'h00);
      b_nan  = (bus.eb_i == 8'hFF) && (bus.mb_i != 7'h00);

      // Order operands so the larger magnitude is "l"; the sign of the result
      // then always comes from s_l and the subtraction never goes negative.
      swap = ({bus.ea_i, bus.ma_i} < {bus.eb_i, bus.mb_i});
      s_l  = swap ? bus.sb_i : bus.sa_i;
      e_l  = swap ? bus.eb_i : bus.ea_i;
      m_l  = {1'b1, (swap ? bus.mb_i : bus.ma_i)};
      s_s  = swap ? bus.sa_i : bus.sb_i;
      e_s  = swap ? bus.ea_i : bus.eb_i;
      m_s  = {1'b1, (swap ? bus.ma_i : bus.mb_i)};

      // Alignment: significand extended with guard/round/sticky positions.
      // Beyond 10 places the whole small operand already sits in the sticky bit.
      e_diff  = e_l - e_s;
      sh      = (e_diff > 8'd10) ? 4'd10 : e_diff[3:0];
      ext_l   = {m_l, 3'b000};
      ext_s   = {m_s, 3'b000};
      lost    = |(ext_s & ((11'd1 << sh) - 11'd1));
      aligned = (ext_s >> sh) | {10'b0, lost};

      if (s_l == s_s)
         sum = {1'b0, ext_l} + {1'b0, aligned};
      else
         sum = {1'b0, ext_l} - {1'b0, aligned};

      // Leading-zero count over the 11-bit magnitude (carry bit handled apart).
      lzc   = 4'd0;
      found = 1'b0;
      for (int i = 10; i >= 0; i--) begin
         if (!found && sum[i]) begin
            lzc   = 4'(10 - i);
            found = 1'b1;
         end
      end

      if (sum[11]) begin
         // carry out: shift right one, folding the dropped bit into sticky
         norm    = {sum[11:2], sum[1] | sum[0]};
         lzc_eff = 4'd0;
      end else begin
         norm    = sum[10:0] << lzc;
         lzc_eff = lzc;
      end

      // Ties-to-even: round up on guard when round/sticky are set or lsb is odd.
      round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
      mant_r   = {1'b0, norm[10:3]} + {8'b0, round_up};
      // A rounding carry only happens from 1.1111111, leaving 1.0000000.
      frac_r   = mant_r[8] ? mant_r[7:1] : mant_r[6:0];
      exp_r    = {2'b00, e_l} + {9'b0, sum[11]} - {6'b0, lzc_eff} + {9'b0, mant_r[8]};

      // Result selection, specials first.
      if (a_nan || b_nan)
         res_next = {1'b0, 8'hFF, 7'h40};
      else if (a_inf && b_inf && (bus.sa_i != bus.sb_i))
         res_next = {1'b0, 8'hFF, 7'h40};
      else if (a_inf)
         res_next = {bus.sa_i, 8'hFF, 7'h00};
      else if (b_inf)
         res_next = {bus.sb_i, 8'hFF, 7'h00};
      else if (a_zero && b_zero)
         res_next = {bus.sa_i & bus.sb_i, 8'h00, 7'h00};
      else if (a_zero)
         res_next = {bus.sb_i, bus.eb_i, bus.mb_i};
      else if (b_zero)
         res_next = {bus.sa_i, bus.ea_i, bus.ma_i};
      else if (sum == 12'd0)
         res_next = 16'h0000;
      else if (exp_r >= 10'sd255)
         res_next = {s_l, 8'hFF, 7'h00};
      else if (exp_r <= 10'sd0)
         res_next = {s_l, 8'h00, 7'h00};
      else
         res_next = {s_l, exp_r[7:0], frac_r};
   end

   always_ff @(posedge clk) begin
      if (!nreset) begin
         valid_reg <= 1'b0;
         res_reg   <= 16'h0000;
      end else begin
         valid_reg <= bus.valid_i;
         res_reg   <= res_next;
      end
   end

   assign bus.valid_o = valid_reg;
   assign bus.s_o     = res_reg[15];
   assign bus.e_o     = res_reg[14:7];
   assign bus.m_o     = res_reg[6:0];

endmodule

// File: tb/tb_bf16_adder.sv
// Directed bench for bf16_adder: reset state, special values, rounding ties,
// overflow/underflow, back-to-back issue, valid timing and mid-stream reset.
module tb_bf16_adder;

   logic clk;
   logic nreset;
   int   n_checks;
   int   n_errors;

   bf16_adder_if bus ();

   bf16_adder dut (
      .clk    (clk),
      .nreset (nreset),
      .bus    (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   localparam int NV = 19;
   logic [15:0] vec_a   [NV] = '{16'h0000, 16'h0000, 16'h8000, 16'h8000, 16'h3F80,
                                 16'h3F80, 16'h3F80, 16'h3F81, 16'h7F7F, 16'h7F80,
                                 16'h7F81, 16'hFF80, 16'h0001, 16'h0080, 16'h3FC0,
                                 16'h3F80, 16'h3FFF, 16'h00FF, 16'h4040};
   logic [15:0] vec_b   [NV] = '{16'h0000, 16'h8000, 16'h8000, 16'h3F80, 16'h3F80,
                                 16'hBF80, 16'h3B80, 16'h3B80, 16'h7F7F, 16'hFF80,
                                 16'h3F80, 16'h3F80, 16'h0000, 16'h8080, 16'hBF80,
                                 16'hC000, 16'h3B80, 16'h8100, 16'h3F80};
   logic [15:0] vec_exp [NV] = '{16'h0000, 16'h0000, 16'h8000, 16'h3F80, 16'h4000,
                                 16'h0000, 16'h3F80, 16'h3F82, 16'h7F80, 16'h7FC0,
                                 16'h7FC0, 16'hFF80, 16'h0000, 16'h0000, 16'h3F00,
                                 16'hBF80, 16'h4000, 16'h8000, 16'h4080};

   task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] want);
      n_checks++;
      if (got !== want) begin
         n_errors++;
         $display("FAIL %s got=%h want=%h", tag, got, want);
      end else begin
         $display("ok   %s got=%h", tag, got);
      end
   endtask

   task automatic drive(input logic v, input logic [15:0] a, input logic [15:0] b);
      bus.valid_i = v;
      bus.sa_i    = a[15];
      bus.ea_i    = a[14:7];
      bus.ma_i    = a[6:0];
      bus.sb_i    = b[15];
      bus.eb_i    = b[14:7];
      bus.mb_i    = b[6:0];
   endtask

   function automatic logic [15:0] result();
      return {bus.s_o, bus.e_o, bus.m_o};
   endfunction

   initial begin
      n_checks = 0;
      n_errors = 0;
      nreset   = 1'b0;
      drive(1'b1, 16'h3F80, 16'h3F80);
      repeat (2) @(posedge clk);
      #1;
      check_val("reset_valid", {15'b0, bus.valid_o}, 16'h0000);
      check_val("reset_result", result(), 16'h0000);

      // back-to-back vectors, one per cycle
      nreset = 1'b1;
      for (int i = 0; i < NV; i++) begin
         drive(1'b1, vec_a[i], vec_b[i]);
         @(posedge clk);
         #1;
         check_val($sformatf("vec%0d %h+%h", i, vec_a[i], vec_b[i]), result(), vec_exp[i]);
         check_val($sformatf("vec%0d_valid", i), {15'b0, bus.valid_o}, 16'h0001);
      end

      // valid pulse: idle, one valid, idle
      drive(1'b0, 16'h3F80, 16'h3F80);
      @(posedge clk); #1;
      check_val("pulse_pre", {15'b0, bus.valid_o}, 16'h0000);
      drive(1'b1, 16'h4040, 16'h3F80);
      @(posedge clk); #1;
      check_val("pulse_hi", {15'b0, bus.valid_o}, 16'h0001);
      check_val("pulse_res", result(), 16'h4080);
      drive(1'b0, 16'h4040, 16'h3F80);
      @(posedge clk); #1;
      check_val("pulse_post", {15'b0, bus.valid_o}, 16'h0000);

      // reset in the middle of a stream of valid operations
      drive(1'b1, 16'h3F80, 16'h3F80);
      @(posedge clk); #1;
      check_val("pre_rst_res", result(), 16'h4000);
      nreset = 1'b0;
      drive(1'b1, 16'h4040, 16'h3F80);
      @(posedge clk); #1;
      check_val("midrst_valid", {15'b0, bus.valid_o}, 16'h0000);
      check_val("midrst_res", result(), 16'h0000);
      nreset = 1'b1;
      drive(1'b1, 16'h3FC0, 16'hBF80);
      @(posedge clk); #1;
      check_val("post_rst_res", result(), 16'h3F00);
      check_val("post_rst_valid", {15'b0, bus.valid_o}, 16'h0001);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
